// File: rtl/cache_control_if.sv
// CPU, physical-memory and datapath control signals of the cache controller.
// Pure wiring bundle, no storage and no latency.
// Handshakes are level-held requests closed by a single-cycle response pulse.
interface cache_control_if;

  // CPU side
  logic mem_read;
  logic mem_write;
  logic mem_resp;

  // Datapath status
  logic hit;
  logic dirty;

  // Physical memory side
  logic pmem_resp;
  logic pmem_read;
  logic pmem_write;

  // Datapath controls
  logic load_cache;
  logic load_mem_wdata;
  logic load_mem_rdata;
  logic load_plru;
  logic dirty_value;
  logic fill_mask;

  // Controller view
  modport master (
    input  mem_read, mem_write, hit, dirty, pmem_resp,
    output mem_resp, pmem_read, pmem_write, load_cache, load_mem_wdata,
           load_mem_rdata, load_plru, dirty_value, fill_mask
  );

  // Environment view (CPU, memory and datapath models)
  modport slave (
    output mem_read, mem_write, hit, dirty, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, load_cache, load_mem_wdata,
           load_mem_rdata, load_plru, dirty_value, fill_mask
  );

endinterface

// File: rtl/cache_control.sv
// Write-back cache controller FSM with saturating hit/miss/write-back counters.
// Hit responds 1 cycle after request; miss adds pmem read (+ write-back) and a fill-settle cycle.
// CPU request is held until mem_resp; pmem requests are held until pmem_resp.
module cache_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_clr,
  cache_control_if.master  bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FILL_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_n;

  logic req;
  logic hit_inc;
  logic miss_inc;
  logic wb_inc;

  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic load_cache;
  logic load_mem_wdata;
  logic load_mem_rdata;
  logic load_plru;
  logic dirty_value;
  logic fill_mask;

  // Either request kind starts a lookup; a simultaneous read and write is a write.
  assign req = bus.mem_read | bus.mem_write;

  // State register; reset returns to IDLE and abandons any pmem transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and control outputs, all derived from state and current inputs.
  always_comb begin
    state_n        = state;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    load_cache     = 1'b0;
    load_mem_wdata = 1'b0;
    load_mem_rdata = 1'b0;
    load_plru      = 1'b0;
    dirty_value    = 1'b0;
    fill_mask      = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;

    unique case (state)
      IDLE: begin
        // One cycle here gives the synchronous tag/data arrays time to read.
        if (req) begin
          state_n = COMPARE;
        end
      end

      COMPARE: begin
        if (!req) begin
          state_n = IDLE;
        end else if (bus.hit) begin
          mem_resp  = 1'b1;
          load_plru = 1'b1;
          hit_inc   = 1'b1;
          if (bus.mem_write) begin
            load_cache     = 1'b1;
            load_mem_wdata = 1'b1;
            dirty_value    = 1'b1;
          end else begin
            load_mem_rdata = 1'b1;
          end
          state_n = IDLE;
        end else begin
          miss_inc = 1'b1;
          state_n  = bus.dirty ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        // Victim must leave before the fill overwrites it; completes even if the CPU drops.
        pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          wb_inc  = 1'b1;
          state_n = ALLOCATE;
        end
      end

      ALLOCATE: begin
        pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          // Fill the whole line from pmem_rdata as a clean line.
          load_cache = 1'b1;
          fill_mask  = 1'b1;
          state_n    = FILL_WAIT;
        end
      end

      FILL_WAIT: begin
        // Arrays need a cycle to present the freshly filled line before the retry.
        state_n = COMPARE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Performance counters: saturate at all-ones, clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc && (hit_cnt != CNT_MAX)) begin
        hit_cnt <= hit_cnt + 1'b1;
      end
      if (miss_inc && (miss_cnt != CNT_MAX)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
      if (wb_inc && (wb_cnt != CNT_MAX)) begin
        wb_cnt <= wb_cnt + 1'b1;
      end
    end
  end

  assign bus.mem_resp       = mem_resp;
  assign bus.pmem_read      = pmem_read;
  assign bus.pmem_write     = pmem_write;
  assign bus.load_cache     = load_cache;
  assign bus.load_mem_wdata = load_mem_wdata;
  assign bus.load_mem_rdata = load_mem_rdata;
  assign bus.load_plru      = load_plru;
  assign bus.dirty_value    = dirty_value;
  assign bus.fill_mask      = fill_mask;

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed scenarios plus randomized traffic.
// Outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// The CPU model holds requests until a response, with occasional early drops.
module tb_cache_control;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  // Bit positions in the packed output vector
  localparam int O_RESP = 8;
  localparam int O_PRD  = 7;
  localparam int O_PWR  = 6;
  localparam int O_LC   = 5;
  localparam int O_LMW  = 4;
  localparam int O_LMR  = 3;
  localparam int O_PLRU = 2;
  localparam int O_DV   = 1;
  localparam int O_FM   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cnt_clr;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;
  logic [CW-1:0] wb_cnt;

  cache_control_if bus();

  cache_control #(.CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_clr  (cnt_clr),
    .bus      (bus.master),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );

  logic [8:0] dut_outs;
  assign dut_outs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_cache,
                     bus.load_mem_wdata, bus.load_mem_rdata, bus.load_plru,
                     bus.dirty_value, bus.fill_mask};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // What the controller is busy with: nothing, looking up tags, evicting the
  // victim, fetching the new line, or letting the fill settle.
  typedef enum int {M_IDLE, M_LOOKUP, M_EVICT, M_FETCH, M_SETTLE} mphase_t;

  mphase_t m_phase     = M_IDLE;
  bit      m_retry     = 1'b0;
  bit      m_resp_last = 1'b0;
  int      m_hits      = 0;
  int      m_misses    = 0;
  int      m_wbs       = 0;

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_step();
    logic [8:0] e;
    mphase_t    nx;
    bit         hi, mi, wi, rq;
    e  = '0;
    nx = m_phase;
    hi = 1'b0;
    mi = 1'b0;
    wi = 1'b0;
    rq = bus.mem_read | bus.mem_write;
    case (m_phase)
      M_IDLE:   if (rq) nx = M_LOOKUP;
      M_LOOKUP: begin
        if (!rq) nx = M_IDLE;
        else if (bus.hit) begin
          e[O_RESP] = 1'b1;
          e[O_PLRU] = 1'b1;
          if (bus.mem_write) begin
            e[O_LC]  = 1'b1;
            e[O_LMW] = 1'b1;
            e[O_DV]  = 1'b1;
          end else begin
            e[O_LMR] = 1'b1;
          end
          hi = 1'b1;
          nx = M_IDLE;
        end else begin
          mi = 1'b1;
          nx = bus.dirty ? M_EVICT : M_FETCH;
        end
      end
      M_EVICT: begin
        e[O_PWR] = 1'b1;
        if (bus.pmem_resp) begin
          wi = 1'b1;
          nx = M_FETCH;
        end
      end
      M_FETCH: begin
        e[O_PRD] = 1'b1;
        if (bus.pmem_resp) begin
          e[O_LC] = 1'b1;
          e[O_FM] = 1'b1;
          nx = M_SETTLE;
        end
      end
      default: nx = M_LOOKUP;
    endcase

    check("outputs", dut_outs, e);
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
    check("wb_cnt", wb_cnt, m_wbs);

    m_resp_last = e[O_RESP];
    m_retry     = (m_phase == M_SETTLE) && !rst;
    if (rst || cnt_clr) begin
      m_hits   = 0;
      m_misses = 0;
      m_wbs    = 0;
    end else begin
      if (hi) m_hits   = sat_inc(m_hits);
      if (mi) m_misses = sat_inc(m_misses);
      if (wi) m_wbs    = sat_inc(m_wbs);
    end
    m_phase = rst ? M_IDLE : nx;
  endtask

  // Compare process: starts after the first reset edge, checks every cycle.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  // ---------------- Stimulus ----------------
  task automatic drive(input bit r, input bit w, input bit h, input bit d,
                       input bit pr, input bit rs, input bit clr);
    @(posedge clk);
    #1;
    bus.mem_read  = r;
    bus.mem_write = w;
    bus.hit       = h;
    bus.dirty     = d;
    bus.pmem_resp = pr;
    rst           = rs;
    cnt_clr       = clr;
  endtask

  task automatic clear_counters();
    drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  bit cpu_act;
  bit cpu_rd;
  bit cpu_wr;
  int k;

  initial begin
    rst           = 1'b1;
    cnt_clr       = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.hit       = 1'b0;
    bus.dirty     = 1'b0;
    bus.pmem_resp = 1'b0;

    // Reset state: all 1-bit outputs and counters zero in IDLE
    drive(0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("reset outputs", dut_outs, 0);
    check("reset counters", {hit_cnt, miss_cnt, wb_cnt}, 0);

    // Read hit: response one cycle after the request
    drive(1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rd hit c0 resp", bus.mem_resp, 0);
    drive(1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rd hit c1 outs", dut_outs, 9'b1_0000_1100);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rd hit hit_cnt", hit_cnt, 1);

    // Clean read miss, pmem answers after 5 cycles
    clear_counters();
    for (int c = 0; c <= 9; c++) begin
      drive(c <= 8, 0, c >= 7, 0, c == 6, 0, 0);
      @(negedge clk);
      check("clean miss pmem_read", bus.pmem_read, (c >= 2 && c <= 6));
      check("clean miss load_cache", bus.load_cache, (c == 6));
      check("clean miss fill_mask", bus.fill_mask, (c == 6));
      check("clean miss mem_resp", bus.mem_resp, (c == 8));
      check("clean miss pmem_write", bus.pmem_write, 0);
    end
    check("clean miss counters", {hit_cnt, miss_cnt, wb_cnt}, {2'd1, 2'd1, 2'd0});

    // Dirty write miss: write-back 3 cycles, fetch 3 cycles, then write hit
    clear_counters();
    for (int c = 0; c <= 10; c++) begin
      drive(0, c <= 9, c >= 8, 1, (c == 4 || c == 7), 0, 0);
      @(negedge clk);
      check("dirty miss pmem_write", bus.pmem_write, (c >= 2 && c <= 4));
      check("dirty miss pmem_read", bus.pmem_read, (c >= 5 && c <= 7));
      check("dirty miss load_cache", bus.load_cache, (c == 7 || c == 9));
      check("dirty miss dirty_value", bus.dirty_value, (c == 9));
      check("dirty miss load_mem_wdata", bus.load_mem_wdata, (c == 9));
      check("dirty miss mem_resp", bus.mem_resp, (c == 9));
    end
    check("dirty miss counters", {hit_cnt, miss_cnt, wb_cnt}, {2'd1, 2'd1, 2'd1});

    // Reset during ALLOCATE; the late pmem_resp must be ignored
    clear_counters();
    for (int c = 0; c <= 6; c++) begin
      drive(c <= 3, 0, 0, 0, c == 5, c == 4, 0);
      @(negedge clk);
      check("rst alloc pmem_read", bus.pmem_read, (c >= 2 && c <= 4));
      check("rst alloc load_cache", bus.load_cache, 0);
      if (c == 3) check("rst alloc miss before", miss_cnt, 1);
      if (c == 5) check("rst alloc counters", {hit_cnt, miss_cnt, wb_cnt}, 0);
    end

    // Saturation: 5 back-to-back read hits, then clear with a concurrent hit
    clear_counters();
    for (int c = 0; c <= 10; c++) drive(1, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("sat hit_cnt", hit_cnt, 3);
    drive(1, 0, 1, 0, 0, 0, 1);
    @(negedge clk);
    check("clr+hit resp", bus.mem_resp, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("clr+hit hit_cnt", hit_cnt, 0);

    // Request dropped in COMPARE
    clear_counters();
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("drop resp", bus.mem_resp, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("drop outs", dut_outs, 0);
    check("drop counters", {hit_cnt, miss_cnt, wb_cnt}, 0);

    // Randomized traffic
    cpu_act = 1'b0;
    cpu_rd  = 1'b0;
    cpu_wr  = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (m_resp_last) cpu_act = 1'b0;
      else if (cpu_act && $urandom_range(19) == 0) cpu_act = 1'b0;
      else if (!cpu_act && $urandom_range(1) == 0) begin
        cpu_act = 1'b1;
        k       = $urandom_range(2);
        cpu_rd  = (k != 1);
        cpu_wr  = (k != 0);
      end
      bus.mem_read  = cpu_act & cpu_rd;
      bus.mem_write = cpu_act & cpu_wr;
      bus.hit       = (m_phase == M_LOOKUP && m_retry) ? 1'b1 : 1'($urandom_range(1));
      bus.dirty     = 1'($urandom_range(1));
      bus.pmem_resp = ($urandom_range(2) == 0);
      rst           = ($urandom_range(199) == 0);
      cnt_clr       = ($urandom_range(15) == 0);
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
